// File: rtl/mdu_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer for the EX stage.
// Stalls the pipeline while busy and strobes HI/LO on completion.
module mdu_seq #(
  parameter int DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        stallreq,
  output logic        busy,
  output logic        hilo_we,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int CW = $clog2(DIV_STEPS);
  localparam logic [CW-1:0] LAST = CW'(DIV_STEPS - 1);

  typedef enum logic [2:0] {
    IDLE, MUL, DIV_RUN, DIV_ZERO, DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   a_q, b_q;
  logic [31:0]   div_b, rem_q, quo_q;
  logic          sx, sign_q, sign_r;

  logic [31:0] abs_a, abs_b;
  logic [32:0] shifted, trial;
  logic [31:0] rem_nx, quo_nx;
  logic [63:0] prod;

  assign abs_a = (~op[0] & src_a[31]) ? -src_a : src_a;
  assign abs_b = (~op[0] & src_b[31]) ? -src_b : src_b;

  // one restoring step on {rem,quo}
  assign shifted = {rem_q, quo_q[31]};
  assign trial   = shifted - {1'b0, div_b};
  assign rem_nx  = trial[32] ? shifted[31:0] : trial[31:0];
  assign quo_nx  = {quo_q[30:0], ~trial[32]};

  // sign-extending to 64 bits makes one multiplier serve both flavours
  assign prod = {{32{sx & a_q[31]}}, a_q} * {{32{sx & b_q[31]}}, b_q};

  assign busy     = (state != IDLE);
  assign hilo_we  = (state == DONE);
  assign stallreq = (state == IDLE && start && !cancel)
                 || state == MUL
                 || state == DIV_RUN
                 || state == DIV_ZERO;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      div_b  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      sx     <= 1'b0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else if (cancel) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          a_q    <= src_a;
          b_q    <= src_b;
          sx     <= ~op[0];
          sign_q <= ~op[0] & (src_a[31] ^ src_b[31]);
          sign_r <= ~op[0] & src_a[31];
          div_b  <= abs_b;
          quo_q  <= abs_a;
          rem_q  <= '0;
          cnt    <= '0;
          if (!op[1])
            state <= MUL;
          else if (src_b == '0)
            state <= DIV_ZERO;
          else
            state <= DIV_RUN;
        end
        MUL: begin
          hi_out <= prod[63:32];
          lo_out <= prod[31:0];
          state  <= DONE;
        end
        DIV_RUN: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            hi_out <= sign_r ? -rem_nx : rem_nx;
            lo_out <= sign_q ? -quo_nx : quo_nx;
            cnt    <= '0;
            state  <= DONE;
          end
        end
        DIV_ZERO: begin
          hi_out <= a_q;
          lo_out <= '1;
          state  <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
Iterative multiply/divide sequencer for the EX stage of the 5-stage MIPS pipeline. It accepts one MULT/MULTU/DIV/DIVU request at a time and sequences a single-cycle multiplier or a 32-step restoring divider. While busy it raises a stall request into the pipeline stall controller. It delivers the HI/LO result with a one-cycle write strobe.

Parameters:
DIV_STEPS, 32, number of radix-2 quotient iterations; fixed for 32-bit operands.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  request valid from EX; sampled only in IDLE
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
src_a  in  32  rs operand (multiplicand or dividend)
src_b  in  32  rt operand (multiplier or divisor)
cancel  in  1  pipeline flush; aborts any operation in flight
stallreq  out  1  asks the stall controller to freeze IF/ID/EX
busy  out  1  state != IDLE
hilo_we  out  1  one-cycle write strobe for HI/LO
hi_out  out  32  HI result (product[63:32] or remainder)
lo_out  out  32  LO result (product[31:0] or quotient)

Behaviour:
- States: IDLE, MUL, DIV_RUN, DIV_ZERO, DONE.
- Reset: state=IDLE, counter=0, all operand/partial registers=0. Outputs stallreq=0, busy=0, hilo_we=0, hi_out=0, lo_out=0.
- IDLE, start=1, cancel=0:
  - Capture the operands.
  - For signed ops, store absolute values and record sign_q = a[31]^b[31] and sign_r = a[31].
  - op[1]=0 -> MUL.
  - op[1]=1 and src_b==0 -> DIV_ZERO.
  - otherwise -> DIV_RUN with counter=0, remainder=0, quotient shift register=|a|.
- stallreq (combinational) = (IDLE & start & ~cancel) | MUL | DIV_RUN | DIV_ZERO. It is 0 in DONE so the stalled instruction advances in the same cycle hilo_we fires.
- MUL (1 cycle): compute the 64-bit product of the operands as captured (signed: {{32{a[31]}},a} * {{32{b[31]}},b}, low 64 bits; unsigned: zero-extended). Register it into hi/lo -> DONE.
- DIV_RUN (DIV_STEPS cycles):
  - Each cycle: shift {rem,quo} left by 1, trial = rem_shifted - |b| (33-bit).
  - If trial is non-negative: rem=trial and the quotient LSB=1; else the LSB=0.
  - counter increments; after the step where counter==DIV_STEPS-1 -> DONE.
  - On exit, apply signs: lo = sign_q ? -quo : quo; hi = sign_r ? -rem : rem (signed ops only).
- DIV_ZERO (1 cycle): hi=src_a as captured, lo=32'hFFFFFFFF -> DONE.
- DONE (1 cycle): hilo_we=1; hi_out/lo_out valid, held stable until the next DONE -> IDLE.
- Latency, start accepted at cycle 0:
  - MUL: DONE at cycle 2.
  - DIV_ZERO: DONE at cycle 2.
  - DIV_RUN: DONE at cycle 33.
- start while not IDLE: ignored (the pipeline is stalled, so it must not occur).
- cancel:
  - In any state, next state=IDLE, counter=0, no hilo_we. hi_out/lo_out keep their previous values.
  - cancel has priority over start in the same cycle.
  - cancel in DONE suppresses nothing; the strobe in that cycle still fires.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (two's-complement wrap, no trap).
- rst mid-operation: returns to IDLE next edge with all outputs zeroed.

Test Plan:
- DIVU a=100, b=7, start at cycle 0 -> stallreq=1 for cycles 0..32; hilo_we=1 at cycle 33 only, with lo=14, hi=2; busy=0 at cycle 34.
- DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF at cycle 33.
- MULT a=0xFFFFFFFF, b=2 -> cycle 2: hi=0xFFFFFFFF, lo=0xFFFFFFFE. Repeat as MULTU -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=5, b=0 -> DIV_ZERO; cycle 2: hilo_we=1, hi=5, lo=0xFFFFFFFF.
- DIVU started, cancel at cycle 10 -> IDLE at cycle 11, stallreq=0, no hilo_we, hi/lo unchanged. A new MULTU 3*4 at cycle 12 -> lo=12, hi=0 at cycle 14.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Separately, start and cancel asserted together in IDLE -> remains IDLE, stallreq=0.
